// File: rtl/sap_pkg.sv
// Shared SAP-computer definitions: address width and address type used by the
// MAR, program counter and RAM.
package sap_pkg;

    localparam int unsigned ADDR_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mar_reg4_ls173.sv
// 74LS173-style register: async active-high clear, active-low load and an
// active-low tri-state output. Reused for the MAR, A, B and IR registers.
module reg4_ls173 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             load_n_i,
    input  logic             oe_n_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (!load_n_i) begin
            addr_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign q_o = oe_n_i ? 'z : addr_q;

endmodule

// File: rtl/mar.sv
// Memory address register: latches an address from the bus and presents it,
// or the front-panel DIP switches in program mode, to the RAM address lines.
module mar
    import sap_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] bus,
    input  logic [WIDTH-1:0] dipswitch_input,
    input  logic             load,
    input  logic             enable,
    input  logic             button_select,
    output logic [WIDTH-1:0] mar_out
);

    logic [WIDTH-1:0] reg_path;

    reg4_ls173 #(
        .WIDTH(WIDTH)
    ) u_addr_reg (
        .clk_i   (clk),
        .clear_i (clear),
        .d_i     (bus),
        .load_n_i(load),
        .oe_n_i  (enable),
        .q_o     (reg_path)
    );

    // 74LS157-style source select; program mode bypasses the register entirely.
    assign mar_out = button_select ? dipswitch_input : reg_path;

endmodule

// File: tb/tb_mar.sv
// Self-checking bench for mar: directed scenarios followed by randomized
// cycles checked against a behavioural address/output model.
module tb_mar;

    logic       clk;
    logic       clear;
    logic [3:0] bus;
    logic [3:0] dipswitch_input;
    logic       load;
    logic       enable;
    logic       button_select;
    logic [3:0] mar_out;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [3:0] model_addr;
    logic [3:0] zval;

    mar #(
        .WIDTH(4)
    ) dut (
        .clk            (clk),
        .clear          (clear),
        .bus            (bus),
        .dipswitch_input(dipswitch_input),
        .load           (load),
        .enable         (enable),
        .button_select  (button_select),
        .mar_out        (mar_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        n_checks++;
        assert (mar_out === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, mar_out, exp);
        end
    endtask

    // Expected output from the model: DIP switches in program mode, otherwise
    // the stored address unless the register output is disabled.
    function automatic logic [3:0] expect_out(input logic [3:0] addr);
        logic [3:0] r;
        if (button_select)   r = dipswitch_input;
        else if (enable)     r = zval;
        else                 r = addr;
        return r;
    endfunction

    initial begin
        zval            = 'z;
        clear           = 1'b1;
        bus             = 4'h0;
        dipswitch_input = 4'h0;
        load            = 1'b1;
        enable          = 1'b0;
        button_select   = 1'b0;

        // Reset state
        #12 clear = 1'b0;
        #1 chk("reset_run", 4'b0000);
        dipswitch_input = 4'b1100;
        button_select   = 1'b1;
        #1 chk("reset_prog", 4'b1100);
        button_select   = 1'b0;

        // Load latency
        @(negedge clk);
        bus  = 4'b0101;
        load = 1'b0;
        #1 chk("pre_load", 4'b0000);
        @(posedge clk);
        #1 chk("load_latency", 4'b0101);

        // Program-mode mux is combinational
        @(negedge clk);
        load            = 1'b1;
        dipswitch_input = 4'b1010;
        button_select   = 1'b1;
        #1 chk("prog_mode", 4'b1010);
        button_select   = 1'b0;
        #1 chk("run_mode_back", 4'b0101);

        // Hold with load high, then tri-state
        bus = 4'b1111;
        repeat (3) @(posedge clk);
        #1 chk("hold", 4'b0101);
        enable = 1'b1;
        #1 chk("disabled_z", zval);
        enable = 1'b0;
        #1 chk("reenabled", 4'b0101);

        // Async clear between edges, held across a load edge
        @(negedge clk);
        #2 clear = 1'b1;
        #1 chk("async_clear", 4'b0000);
        load = 1'b0;
        bus  = 4'b0111;
        @(posedge clk);
        #1 chk("clear_blocks_load", 4'b0000);
        @(negedge clk);
        clear = 1'b0;
        bus   = 4'b1001;
        #1 chk("after_clear_release", 4'b0000);
        @(posedge clk);
        #1 chk("first_load_after_clear", 4'b1001);

        // Clear coinciding with a load edge
        @(negedge clk);
        bus = 4'b0110;
        @(posedge clk);
        clear = 1'b1;
        #1 chk("clear_at_edge", 4'b0000);
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b1;

        // Load while output disabled
        @(negedge clk);
        enable = 1'b1;
        load   = 1'b0;
        bus    = 4'b0011;
        @(posedge clk);
        #1 chk("load_disabled_z", zval);
        @(negedge clk);
        load   = 1'b1;
        enable = 1'b0;
        #1 chk("load_disabled_val", 4'b0011);

        // Load while in program mode
        @(negedge clk);
        button_select   = 1'b1;
        dipswitch_input = 4'b0001;
        load            = 1'b0;
        bus             = 4'b1100;
        @(posedge clk);
        #1 chk("load_prog_mode", 4'b0001);
        @(negedge clk);
        load          = 1'b1;
        button_select = 1'b0;
        #1 chk("load_prog_val", 4'b1100);

        // Randomized phase, synchronized to the model by a clear pulse
        @(negedge clk);
        clear = 1'b1;
        model_addr = 4'h0;
        #1 clear = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            clear           = 1'b0;
            bus             = 4'($urandom);
            dipswitch_input = 4'($urandom);
            load            = ($urandom_range(0, 2) == 0);
            enable          = ($urandom_range(0, 3) == 0);
            button_select   = ($urandom_range(0, 3) == 0);
            #1 chk("rand_comb", expect_out(model_addr));
            if ($urandom_range(0, 15) == 0) begin
                #1 clear = 1'b1;
                model_addr = 4'h0;
                #1 chk("rand_clear", expect_out(model_addr));
            end
            @(posedge clk);
            if (!clear && !load) model_addr = bus;
            #1 chk("rand_edge", expect_out(model_addr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
